// File: rtl/sd_access_scheduler_if.sv
// Handshake bundle between the access scheduler, the UART sector buffer and the SD controller.
// master = scheduler side, slave = buffer/controller side.
interface sd_access_scheduler_if;
    logic        init_end;
    logic        wr_buf_full;
    logic        wr_buf_ack;
    logic        sd_wr_req;
    logic [31:0] sd_wr_addr;
    logic        sd_wr_busy;
    logic        sd_rd_req;
    logic [31:0] sd_rd_addr;
    logic        sd_rd_busy;

    modport master (
        input  init_end,
        input  wr_buf_full,
        input  sd_wr_busy,
        input  sd_rd_busy,
        output wr_buf_ack,
        output sd_wr_req,
        output sd_wr_addr,
        output sd_rd_req,
        output sd_rd_addr
    );

    modport slave (
        output init_end,
        output wr_buf_full,
        output sd_wr_busy,
        output sd_rd_busy,
        input  wr_buf_ack,
        input  sd_wr_req,
        input  sd_wr_addr,
        input  sd_rd_req,
        input  sd_rd_addr
    );
endinterface

// File: rtl/sd_access_scheduler.sv
// Shares the SD sector interface between UART sector writes and button-triggered readback.
// Owns the write/read sector pointers, round-robin arbitration and the busy-rise timeout.
module sd_access_scheduler #(
    parameter int unsigned START_SECTOR    = 2048,
    parameter int unsigned MAX_SECTORS     = 65536,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         button,
    sd_access_scheduler_if.master        bus,
    output logic                         rd_active,
    output logic                         card_full,
    output logic                         err
);

    localparam logic [31:0] FIRST_SECTOR = 32'(START_SECTOR);
    localparam logic [31:0] END_SECTOR   = 32'(START_SECTOR + MAX_SECTORS);
    localparam logic [31:0] DEB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] TMO_LIMIT    = 32'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        StInitWait,
        StIdle,
        StWrReq,
        StWrWaitBusy,
        StWrWaitDone,
        StRdReq,
        StRdWaitBusy,
        StRdWaitDone,
        StError
    } state_t;

    // Button synchroniser and debouncer
    logic [1:0]  btn_sync_q;
    logic        btn_s;
    logic        deb_pressed_q, deb_pressed_d;
    logic [31:0] deb_cnt_q, deb_cnt_d;
    logic        press_evt;

    assign btn_s = btn_sync_q[1];

    // Count samples that disagree with the accepted level (low while released, high while pressed).
    always_comb begin
        deb_pressed_d = deb_pressed_q;
        deb_cnt_d     = '0;
        press_evt     = 1'b0;
        if (btn_s == deb_pressed_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_pressed_d = ~deb_pressed_q;
                press_evt     = ~deb_pressed_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 32'd1;
            end
        end
    end

    // Scheduler
    state_t      state_q, state_d;
    logic [31:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] rd_ptr_q, rd_ptr_d;
    logic        rd_pending_q, rd_pending_d;
    logic        last_rd_q, last_rd_d;
    logic [31:0] tmo_q, tmo_d;
    logic        ack_q, ack_d;
    logic        wr_cand, rd_cand;

    // The buffer is still flagged full during the ack cycle; it is not a new sector yet.
    assign wr_cand = bus.wr_buf_full & ~card_full & ~ack_q;
    assign rd_cand = rd_pending_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_pending_d = rd_pending_q;
        last_rd_d    = last_rd_q;
        tmo_d        = tmo_q;
        ack_d        = 1'b0;

        if (press_evt && !rd_pending_q && (wr_ptr_q > FIRST_SECTOR)) begin
            rd_pending_d = 1'b1;
            rd_ptr_d     = FIRST_SECTOR;
        end

        unique case (state_q)
            StInitWait: begin
                if (bus.init_end) state_d = StIdle;
            end
            StIdle: begin
                if (!bus.init_end) begin
                    state_d = StInitWait;
                end else if (wr_cand && (!rd_cand || last_rd_q)) begin
                    state_d = StWrReq;
                end else if (rd_cand) begin
                    state_d = StRdReq;
                end
            end
            StWrReq: begin
                tmo_d   = '0;
                state_d = StWrWaitBusy;
            end
            StWrWaitBusy: begin
                if (bus.sd_wr_busy) begin
                    state_d = StWrWaitDone;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                    if (tmo_d == TMO_LIMIT) state_d = StError;
                end
            end
            StWrWaitDone: begin
                if (!bus.sd_wr_busy) begin
                    ack_d     = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 32'd1;
                    last_rd_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StRdReq: begin
                tmo_d   = '0;
                state_d = StRdWaitBusy;
            end
            StRdWaitBusy: begin
                if (bus.sd_rd_busy) begin
                    state_d = StRdWaitDone;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                    if (tmo_d == TMO_LIMIT) state_d = StError;
                end
            end
            StRdWaitDone: begin
                if (!bus.sd_rd_busy) begin
                    rd_ptr_d  = rd_ptr_q + 32'd1;
                    last_rd_d = 1'b1;
                    if (rd_ptr_q + 32'd1 == wr_ptr_q) rd_pending_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StInitWait;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            btn_sync_q    <= 2'b11;
            deb_pressed_q <= 1'b0;
            deb_cnt_q     <= '0;
            state_q       <= StInitWait;
            wr_ptr_q      <= FIRST_SECTOR;
            rd_ptr_q      <= FIRST_SECTOR;
            rd_pending_q  <= 1'b0;
            last_rd_q     <= 1'b1;
            tmo_q         <= '0;
            ack_q         <= 1'b0;
        end else begin
            btn_sync_q    <= {btn_sync_q[0], button};
            deb_pressed_q <= deb_pressed_d;
            deb_cnt_q     <= deb_cnt_d;
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_pending_q  <= rd_pending_d;
            last_rd_q     <= last_rd_d;
            tmo_q         <= tmo_d;
            ack_q         <= ack_d;
        end
    end

    // Addresses follow the pointers, which only move on the return to idle.
    assign bus.sd_wr_req  = (state_q == StWrReq);
    assign bus.sd_wr_addr = wr_ptr_q;
    assign bus.sd_rd_req  = (state_q == StRdReq);
    assign bus.sd_rd_addr = rd_ptr_q;
    assign bus.wr_buf_ack = ack_q;
    assign rd_active      = rd_pending_q;
    assign card_full      = (wr_ptr_q == END_SECTOR);
    assign err            = (state_q == StError);

endmodule

// File: tb/tb_sd_access_scheduler.sv
// Directed bench: a full-size instance and a two-sector instance share stimulus and a
// simple controller model that raises busy 3 cycles after a request for 20 cycles.
module tb_sd_access_scheduler;

    localparam int unsigned DEB = 200;
    localparam int unsigned TMO = 64;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_rst, button, init_end, wr_buf_full, hang;
    logic [1:0] rd_active, card_full, err;
    logic [1:0] wbusy, rbusy, wreq, rreq;
    int         wt [2];
    int         rt [2];
    int         wr_reqs [2];
    int         rd_reqs [2];
    int         acks [2];
    logic [31:0] wr_log0 [$];
    logic [31:0] rd_log0 [$];
    bit          grant0 [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    sd_access_scheduler_if bus0 ();
    sd_access_scheduler_if bus1 ();

    assign bus0.init_end    = init_end;
    assign bus1.init_end    = init_end;
    assign bus0.wr_buf_full = wr_buf_full;
    assign bus1.wr_buf_full = wr_buf_full;
    assign bus0.sd_wr_busy  = wbusy[0];
    assign bus1.sd_wr_busy  = wbusy[1];
    assign bus0.sd_rd_busy  = rbusy[0];
    assign bus1.sd_rd_busy  = rbusy[1];
    assign wreq = {bus1.sd_wr_req, bus0.sd_wr_req};
    assign rreq = {bus1.sd_rd_req, bus0.sd_rd_req};

    sd_access_scheduler #(
        .START_SECTOR(2048), .MAX_SECTORS(65536), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .button(button), .bus(bus0),
        .rd_active(rd_active[0]), .card_full(card_full[0]), .err(err[0])
    );

    sd_access_scheduler #(
        .START_SECTOR(2048), .MAX_SECTORS(2), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
    ) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .button(button), .bus(bus1),
        .rd_active(rd_active[1]), .card_full(card_full[1]), .err(err[1])
    );

    // Controller model: timer starts on the request, busy while timer is 3..22
    always @(posedge sys_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sys_rst) begin
                wt[i] <= 0;
                rt[i] <= 0;
            end else begin
                if (wreq[i] && !hang)  wt[i] <= 1;
                else if (wt[i] == 23)  wt[i] <= 0;
                else if (wt[i] != 0)   wt[i] <= wt[i] + 1;
                if (rreq[i] && !hang)  rt[i] <= 1;
                else if (rt[i] == 23)  rt[i] <= 0;
                else if (rt[i] != 0)   rt[i] <= rt[i] + 1;
            end
        end
    end
    assign wbusy[0] = (wt[0] >= 3) && (wt[0] <= 22);
    assign wbusy[1] = (wt[1] >= 3) && (wt[1] <= 22);
    assign rbusy[0] = (rt[0] >= 3) && (rt[0] <= 22);
    assign rbusy[1] = (rt[1] >= 3) && (rt[1] <= 22);

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_reqs[i] <= 0;
                rd_reqs[i] <= 0;
                acks[i]    <= 0;
            end
            wr_log0.delete();
            rd_log0.delete();
            grant0.delete();
        end else begin
            if (wreq[0]) begin
                wr_reqs[0] <= wr_reqs[0] + 1;
                wr_log0.push_back(bus0.sd_wr_addr);
                grant0.push_back(1'b0);
            end
            if (rreq[0]) begin
                rd_reqs[0] <= rd_reqs[0] + 1;
                rd_log0.push_back(bus0.sd_rd_addr);
                grant0.push_back(1'b1);
            end
            if (wreq[1]) wr_reqs[1] <= wr_reqs[1] + 1;
            if (rreq[1]) rd_reqs[1] <= rd_reqs[1] + 1;
            if (bus0.wr_buf_ack) acks[0] <= acks[0] + 1;
            if (bus1.wr_buf_ack) acks[1] <= acks[1] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst     = 1'b1;
        wr_buf_full = 1'b0;
        button      = 1'b1;
        hang        = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    // Offer one sector and release it on the ack, as the UART buffer would
    task automatic write_sector();
        int base;
        base        = acks[0];
        wr_buf_full = 1'b1;
        for (int k = 0; k < 100 && acks[0] == base; k++) tick();
        wr_buf_full = 1'b0;
        check("wr_ack_seen", acks[0], base + 1);
    endtask

    task automatic wait_rd_idle(input string tag, input int budget);
        for (int k = 0; k < budget && rd_active[0]; k++) tick();
        check(tag, rd_active[0], 0);
    endtask

    initial begin
        int fi;
        logic ok;
        init_end = 1'b0;
        do_reset();

        check("rst_wr_req", wreq[0], 0);
        check("rst_rd_req", rreq[0], 0);
        check("rst_wr_addr", bus0.sd_wr_addr, 2048);
        check("rst_rd_addr", bus0.sd_rd_addr, 2048);
        check("rst_ack", bus0.wr_buf_ack, 0);
        check("rst_rd_active", rd_active[0], 0);
        check("rst_card_full", card_full[0], 0);
        check("rst_err", err[0], 0);

        wr_buf_full = 1'b1;
        repeat (10) tick();
        check("no_write_before_init", wr_reqs[0], 0);
        wr_buf_full = 1'b0;
        init_end    = 1'b1;
        tick();

        // Press with nothing written is ignored
        button = 1'b0;
        repeat (DEB + 10) tick();
        check("empty_press_active", rd_active[0], 0);
        button = 1'b1;
        repeat (DEB + 10) tick();
        check("empty_press_rd", rd_reqs[0], 0);

        write_sector();
        repeat (10) tick();
        check("first_wr_addr", wr_log0[0], 2048);
        check("one_wr_req", wr_reqs[0], 1);
        check("one_ack", acks[0], 1);
        check("wr_ptr_2049", bus0.sd_wr_addr, 2049);

        write_sector();
        write_sector();
        repeat (5) tick();
        check("second_wr_addr", wr_log0[1], 2049);
        check("third_wr_addr", wr_log0[2], 2050);
        check("wr_ptr_2051", bus0.sd_wr_addr, 2051);
        check("big_not_full", card_full[0], 0);
        check("small_full", card_full[1], 1);
        check("small_wr_reqs", wr_reqs[1], 2);
        check("small_wr_ptr", bus1.sd_wr_addr, 2050);

        // Short bounce is shorter than the debounce window
        button = 1'b0;
        repeat (DEB / 2) tick();
        button = 1'b1;
        repeat (DEB + 10) tick();
        check("bounce_active", rd_active[0], 0);
        check("bounce_rd", rd_reqs[0], 0);

        button = 1'b0;
        repeat (DEB - 5) tick();
        check("press_early", rd_active[0], 0);
        repeat (15) tick();
        check("press_active", rd_active[0], 1);
        button = 1'b1;
        wait_rd_idle("readback_done", 600);
        check("rd_count", rd_reqs[0], 3);
        check("rd_addr0", rd_log0[0], 2048);
        check("rd_addr1", rd_log0[1], 2049);
        check("rd_addr2", rd_log0[2], 2050);
        check("small_rd_count", rd_reqs[1], 2);
        check("small_rd_idle", rd_active[1], 0);

        // Round robin with both requesters busy
        do_reset();
        wr_buf_full = 1'b1;
        button      = 1'b0;
        for (int k = 0; k < DEB + 60 && !rd_active[0]; k++) tick();
        check("rr_pending", rd_active[0], 1);
        repeat (200) tick();
        wr_buf_full = 1'b0;
        button      = 1'b1;
        wait_rd_idle("rr_read_done", 3000);
        fi = -1;
        for (int k = 0; k < grant0.size(); k++) if (grant0[k] && fi < 0) fi = k;
        ok = (fi >= 1) && (fi + 3 < grant0.size());
        check("rr_window", ok, 1);
        if (ok) begin
            check("rr_w_before", grant0[fi - 1], 0);
            check("rr_w1", grant0[fi + 1], 0);
            check("rr_r1", grant0[fi + 2], 1);
            check("rr_w2", grant0[fi + 3], 0);
        end
        check("rr_all_read", rd_reqs[0], acks[0]);
        check("rr_rd_first", rd_log0[0], 2048);

        // Reset in the middle of the small instance's second read
        do_reset();
        write_sector();
        write_sector();
        button = 1'b0;
        for (int k = 0; k < DEB + 60 && !rd_active[1]; k++) tick();
        button = 1'b1;
        for (int k = 0; k < 100 && rd_reqs[1] < 2; k++) tick();
        check("mr_second_read", rd_reqs[1], 2);
        repeat (5) tick();
        sys_rst = 1'b1;
        tick();
        check("mr_rd_req", rreq[1], 0);
        check("mr_rd_addr", bus1.sd_rd_addr, 2048);
        check("mr_wr_addr", bus1.sd_wr_addr, 2048);
        check("mr_ack", bus1.wr_buf_ack, 0);
        check("mr_rd_active", rd_active[1], 0);
        check("mr_card_full", card_full[1], 0);
        check("mr_err", err[1], 0);
        sys_rst = 1'b0;
        tick();
        tick();

        // Controller never raises busy
        hang        = 1'b1;
        wr_buf_full = 1'b1;
        for (int k = 0; k < 20 && !wreq[0]; k++) tick();
        check("to_req", wreq[0], 1);
        repeat (TMO) tick();
        check("to_err_early", err[0], 0);
        tick();
        check("to_err", err[0], 1);
        repeat (50) tick();
        check("to_err_sticky", err[0], 1);
        check("to_no_retry", wr_reqs[0], 1);
        do_reset();
        check("to_err_cleared", err[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_access_scheduler.md
# sd_access_scheduler

Sequences and shares the SD card sector interface between two requesters: the UART receive path, which delivers full 512-byte sectors to be written, and a button-triggered readback path, which streams previously written sectors back out over UART TX. It sits between the UART sector buffers and the SD card command/data controller inside the SD-over-UART top level. It owns the write and read sector pointers, arbitrates round-robin, and detects a controller that never responds.

## Interface
- START_SECTOR, 2048: first sector address used for write and readback
- MAX_SECTORS, 65536: sectors available from START_SECTOR; the write pointer never exceeds START_SECTOR+MAX_SECTORS
- DEBOUNCE_CYCLES, 1000000: stable-low cycles (20 ms at 50 MHz) required to accept a button press
- TIMEOUT_CYCLES, 4096: maximum cycles from a request pulse to the controller's busy rise

Ports:
- sys_clk  in  1  clock, 50 MHz
- sys_rst  in  1  reset; one clock, synchronous, active-high
- button  in  1  raw push button, active-low, asynchronous
- init_end  in  1  SD controller initialisation complete (level)
- wr_buf_full  in  1  UART side holds one complete sector ready to write (level)
- wr_buf_ack  out  1  one-cycle pulse; the sector write finished and the buffer may be released
- sd_wr_req  out  1  one-cycle write start pulse to the SD controller
- sd_wr_addr  out  32  write sector address
- sd_wr_busy  in  1  controller write in progress
- sd_rd_req  out  1  one-cycle read start pulse
- sd_rd_addr  out  32  read sector address
- sd_rd_busy  in  1  controller read in progress
- rd_active  out  1  readback session in progress; selects the SD read data as the UART TX source
- card_full  out  1  write pointer has reached the end of the region
- err  out  1  sticky timeout flag

## Operation
- Button path:
  - 2-flop synchroniser, then a debounce counter.
  - After DEBOUNCE_CYCLES consecutive low samples, emit exactly one press event.
  - Re-arms only after DEBOUNCE_CYCLES consecutive high samples.
- Press event handling:
  - If wr_ptr > START_SECTOR, set rd_pending and load rd_ptr = START_SECTOR.
  - Otherwise ignore the press.
  - A press while rd_pending=1 is ignored.
- States: INIT_WAIT, IDLE, WR_REQ, WR_WAIT_BUSY, WR_WAIT_DONE, RD_REQ, RD_WAIT_BUSY, RD_WAIT_DONE, ERROR.
- INIT_WAIT -> IDLE when init_end=1.
- IDLE:
  - If init_end=0, go to INIT_WAIT.
  - A write candidate exists when wr_buf_full=1 and card_full=0.
  - A read candidate exists when rd_pending=1.
  - One candidate only: grant it.
  - Both candidates: grant the one not granted last (last_grant resets to "read", so write wins the first tie).
- WR_REQ:
  - sd_wr_req=1 for one cycle, sd_wr_addr=wr_ptr.
  - Next state WR_WAIT_BUSY.
- WR_WAIT_BUSY:
  - On sd_wr_busy=1, go to WR_WAIT_DONE.
  - If the timeout counter reaches TIMEOUT_CYCLES first, go to ERROR.
- WR_WAIT_DONE, on sd_wr_busy=0:
  - Pulse wr_buf_ack.
  - wr_ptr += 1.
  - last_grant = write.
  - Go to IDLE.
- Read path is the mirror of the write path using rd_ptr, with these differences:
  - On completion, rd_ptr += 1 and last_grant = read.
  - If the new rd_ptr == wr_ptr, clear rd_pending.
  - No ack pulse is produced.
- rd_active = rd_pending.
- card_full = (wr_ptr == START_SECTOR+MAX_SECTORS). The pointer stops there and never wraps.
- ERROR:
  - err=1.
  - No further requests are issued.
  - Left only by sys_rst.
- init_end is sampled only in INIT_WAIT and IDLE. A drop mid-transfer is ignored until the transfer completes or times out.

## Timing
- Reset values:
  - State INIT_WAIT.
  - wr_ptr = rd_ptr = START_SECTOR; sd_wr_addr = sd_rd_addr = START_SECTOR.
  - All 1-bit outputs 0; rd_pending = 0; debounce state = released.
- sys_rst asserted mid-transfer: next cycle the state is INIT_WAIT, pointers return to START_SECTOR, and no ack is issued.
- Latency:
  - IDLE grant -> req pulse: 1 cycle, with the address valid in the same cycle.
  - Address is held stable until the state returns to IDLE.
- Busy fall -> wr_buf_ack pulse and pointer increment: the next clock edge.
- Timeout counter:
  - Clears on entry to *_WAIT_BUSY.
  - ERROR is entered on the cycle the count equals TIMEOUT_CYCLES.
- wr_buf_full held high across an ack: a new write request is not issued before the cycle after the return to IDLE.

## Test plan
- Reset, then init_end=1, then wr_buf_full=1, with the controller model asserting busy after 3 cycles for 20 cycles:
  - sd_wr_req pulses once with sd_wr_addr=2048.
  - Exactly one wr_buf_ack follows.
  - wr_ptr becomes 2049.
- Three sectors written, then a button held low for DEBOUNCE_CYCLES:
  - rd_active=1.
  - Read requests issue at addresses 2048, 2049, 2050.
  - rd_active=0 after the third completes.
- Button pressed with zero sectors written: no rd_req and rd_active stays 0. A 100-cycle bounce pulse produces no event.
- wr_buf_full held high while rd_pending=1: grants alternate W, R, W, R (write first after reset).
- Controller never asserts busy after a request: err=1 exactly TIMEOUT_CYCLES cycles after the request and stays 1. sys_rst clears it.
- MAX_SECTORS=2 with two sectors written: card_full=1 and a third wr_buf_full produces no request. sys_rst pulsed mid-read returns all outputs to their reset values.
